buffer_scheduler: RTL and testbench

Sequencer and arbiter that owns the control side of the on-chip memory buffer. It shares the buffer between a host port and a compute port. The host port does single-bank load/unload bursts in mode 0. The compute port does all-bank streaming read-then-writeback bursts in mode 1, with the writeback delayed by a fixed PE pipeline latency. The block drives the buffer's mode, enables and addresses; data buses connect directly between the host/PE array and the buffer.

---
 rtl/buffer_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_buffer_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_scheduler.sv
// buffer_scheduler: control-side sequencer/arbiter for the shared on-chip buffer.
// Shares the buffer between a host port (single-bank load/unload bursts, mode 0)
// and a compute port (all-bank read stream plus delayed writeback, mode 1).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   h_req/h_wr/h_bank/h_base/h_len host burst request and fields
//   h_ack, h_done                 host grant and completion pulses
//   h_valid/h_ready               host write-word handshake
//   h_rvalid                      buffer read data valid (one cycle after r_en)
//   c_req/c_rd_base/c_wr_base/c_len compute burst request and fields
//   c_ack, c_done                 compute grant and completion pulses
//   busy, mode                    not-idle flag, buffer mode select
//   m0_*                          mode 0 per-bank enables and addresses
//   m1_*                          mode 1 broadcast enables and addresses
module buffer_scheduler #(
  parameter int N_BUF    = 8,
  parameter int ADDR_RAM = 10,
  parameter int PE_LAT   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       h_req,
  input  logic                       h_wr,
  input  logic [$clog2(N_BUF)-1:0]   h_bank,
  input  logic [ADDR_RAM-1:0]        h_base,
  input  logic [ADDR_RAM:0]          h_len,
  output logic                       h_ack,
  input  logic                       h_valid,
  output logic                       h_ready,
  output logic                       h_rvalid,
  output logic                       h_done,
  input  logic                       c_req,
  input  logic [ADDR_RAM-1:0]        c_rd_base,
  input  logic [ADDR_RAM-1:0]        c_wr_base,
  input  logic [ADDR_RAM:0]          c_len,
  output logic                       c_ack,
  output logic                       c_done,
  output logic                       busy,
  output logic                       mode,
  output logic [N_BUF-1:0]           m0_w_en,
  output logic [N_BUF-1:0]           m0_r_en,
  output logic [ADDR_RAM-1:0]        m0_w_addr,
  output logic [ADDR_RAM-1:0]        m0_r_addr,
  output logic                       m1_w_en,
  output logic                       m1_r_en,
  output logic [ADDR_RAM-1:0]        m1_w_addr,
  output logic [ADDR_RAM-1:0]        m1_r_addr
);

  typedef enum logic [2:0] {IDLE, SETUP, H_WR, H_RD, COMP} state_t;

  localparam logic [ADDR_RAM:0] LEN_ONE = 1;

  state_t                    state_q, state_d;
  logic                      sel_c_q, sel_c_d;    // current burst belongs to compute
  logic                      last_c_q, last_c_d;  // last grant went to compute
  logic                      mode_q, mode_d;
  logic                      wr_q, wr_d;
  logic [$clog2(N_BUF)-1:0]  bank_q, bank_d;
  logic [ADDR_RAM-1:0]       base_q, base_d;      // host base or compute read base
  logic [ADDR_RAM-1:0]       wbase_q, wbase_d;    // compute writeback base
  logic [ADDR_RAM:0]         len_q, len_d;
  logic [ADDR_RAM:0]         cnt_q, cnt_d;        // words issued/accepted
  logic [ADDR_RAM:0]         wcnt_q, wcnt_d;      // writebacks issued
  logic [PE_LAT-1:0]         vld_pipe_q, vld_pipe_d;
  logic                      h_rvalid_q, h_rvalid_d;
  logic                      h_done_q, h_done_d;
  logic                      c_done_q, c_done_d;

  logic [N_BUF-1:0]          bank_oh;
  logic [ADDR_RAM:0]         len_m1;

  assign bank_oh  = N_BUF'(1) << bank_q;
  assign len_m1   = len_q - LEN_ONE;

  assign mode     = mode_q;
  assign busy     = (state_q != IDLE);
  assign h_rvalid = h_rvalid_q;
  assign h_done   = h_done_q;
  assign c_done   = c_done_q;

  always_comb begin
    state_d   = state_q;
    sel_c_d   = sel_c_q;
    last_c_d  = last_c_q;
    mode_d    = mode_q;
    wr_d      = wr_q;
    bank_d    = bank_q;
    base_d    = base_q;
    wbase_d   = wbase_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    h_done_d  = 1'b0;
    c_done_d  = 1'b0;
    h_ack     = 1'b0;
    c_ack     = 1'b0;
    h_ready   = 1'b0;
    m0_w_en   = '0;
    m0_r_en   = '0;
    m0_w_addr = '0;
    m0_r_addr = '0;
    m1_w_en   = 1'b0;
    m1_r_en   = 1'b0;
    m1_w_addr = '0;
    m1_r_addr = '0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        wcnt_d = '0;
        // On contention the port that was not granted last wins.
        if (h_req && (!c_req || last_c_q)) begin
          state_d  = SETUP;
          sel_c_d  = 1'b0;
          last_c_d = 1'b0;
          mode_d   = 1'b0;
          wr_d     = h_wr;
          bank_d   = h_bank;
          base_d   = h_base;
          len_d    = h_len;
        end else if (c_req) begin
          state_d  = SETUP;
          sel_c_d  = 1'b1;
          last_c_d = 1'b1;
          mode_d   = 1'b1;
          base_d   = c_rd_base;
          wbase_d  = c_wr_base;
          len_d    = c_len;
        end
      end

      SETUP: begin
        h_ack = !sel_c_q;
        c_ack = sel_c_q;
        if (len_q == '0) begin
          state_d  = IDLE;
          h_done_d = !sel_c_q;
          c_done_d = sel_c_q;
        end else if (sel_c_q) begin
          state_d = COMP;
        end else begin
          state_d = wr_q ? H_WR : H_RD;
        end
      end

      H_WR: begin
        h_ready   = (cnt_q < len_q);
        m0_w_addr = base_q + cnt_q[ADDR_RAM-1:0];
        if (h_valid && h_ready) begin
          m0_w_en = bank_oh;
          cnt_d   = cnt_q + LEN_ONE;
          if (cnt_q == len_m1) begin
            state_d  = IDLE;
            h_done_d = 1'b1;
          end
        end
      end

      H_RD: begin
        m0_r_addr = base_q + cnt_q[ADDR_RAM-1:0];
        if (cnt_q < len_q) begin
          m0_r_en = bank_oh;
          cnt_d   = cnt_q + LEN_ONE;
        end else begin
          // Extra cycle lets the final word's h_rvalid go out before done.
          state_d  = IDLE;
          h_done_d = 1'b1;
        end
      end

      COMP: begin
        m1_r_addr = base_q + cnt_q[ADDR_RAM-1:0];
        m1_w_addr = wbase_q + wcnt_q[ADDR_RAM-1:0];
        if (cnt_q < len_q) begin
          m1_r_en = 1'b1;
          cnt_d   = cnt_q + LEN_ONE;
        end
        // Burst ends when the last writeback leaves the PE delay line.
        if (vld_pipe_q[PE_LAT-1]) begin
          m1_w_en = 1'b1;
          wcnt_d  = wcnt_q + LEN_ONE;
          if (wcnt_q == len_m1) begin
            state_d  = IDLE;
            c_done_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    h_rvalid_d    = |m0_r_en;
    vld_pipe_d[0] = m1_r_en;
    for (int i = 1; i < PE_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_c_q    <= 1'b0;
      last_c_q   <= 1'b1;
      mode_q     <= 1'b0;
      wr_q       <= 1'b0;
      bank_q     <= '0;
      base_q     <= '0;
      wbase_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      vld_pipe_q <= '0;
      h_rvalid_q <= 1'b0;
      h_done_q   <= 1'b0;
      c_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_c_q    <= sel_c_d;
      last_c_q   <= last_c_d;
      mode_q     <= mode_d;
      wr_q       <= wr_d;
      bank_q     <= bank_d;
      base_q     <= base_d;
      wbase_q    <= wbase_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      vld_pipe_q <= vld_pipe_d;
      h_rvalid_q <= h_rvalid_d;
      h_done_q   <= h_done_d;
      c_done_q   <= c_done_d;
    end
  end

endmodule

// File: tb/tb_buffer_scheduler.sv
// Bench for buffer_scheduler: a cycle-indexed expectation table is filled from
// the burst timing rules when each request is issued; one process compares all
// outputs against it every cycle, and a few literal checks pin the table.
module tb_buffer_scheduler;
  localparam int N_BUF    = 8;
  localparam int ADDR_RAM = 10;
  localparam int PE_LAT   = 4;
  localparam int BW       = $clog2(N_BUF);
  localparam int MAXC     = 512;

  logic clk = 1'b0;
  logic rst;
  logic h_req, h_wr, h_valid, c_req;
  logic [BW-1:0] h_bank;
  logic [ADDR_RAM-1:0] h_base, c_rd_base, c_wr_base;
  logic [ADDR_RAM:0] h_len, c_len;
  logic h_ack, h_ready, h_rvalid, h_done, c_ack, c_done, busy, mode;
  logic [N_BUF-1:0] m0_w_en, m0_r_en;
  logic [ADDR_RAM-1:0] m0_w_addr, m0_r_addr, m1_w_addr, m1_r_addr;
  logic m1_w_en, m1_r_en;

  buffer_scheduler #(.N_BUF(N_BUF), .ADDR_RAM(ADDR_RAM), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_wr(h_wr), .h_bank(h_bank), .h_base(h_base), .h_len(h_len),
    .h_ack(h_ack), .h_valid(h_valid), .h_ready(h_ready), .h_rvalid(h_rvalid),
    .h_done(h_done), .c_req(c_req), .c_rd_base(c_rd_base), .c_wr_base(c_wr_base),
    .c_len(c_len), .c_ack(c_ack), .c_done(c_done), .busy(busy), .mode(mode),
    .m0_w_en(m0_w_en), .m0_r_en(m0_r_en), .m0_w_addr(m0_w_addr), .m0_r_addr(m0_r_addr),
    .m1_w_en(m1_w_en), .m1_r_en(m1_r_en), .m1_w_addr(m1_w_addr), .m1_r_addr(m1_r_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs, indexed by cycle.
  bit exp_h_ack[MAXC], exp_c_ack[MAXC], exp_h_ready[MAXC], exp_h_rvalid[MAXC];
  bit exp_h_done[MAXC], exp_c_done[MAXC], exp_busy[MAXC], exp_mode[MAXC];
  bit exp_m1_w_en[MAXC], exp_m1_r_en[MAXC], exp_zero[MAXC];
  logic [N_BUF-1:0] exp_m0_w_en[MAXC], exp_m0_r_en[MAXC];
  logic [ADDR_RAM-1:0] exp_m0_w_addr[MAXC], exp_m0_r_addr[MAXC];
  logic [ADDR_RAM-1:0] exp_m1_w_addr[MAXC], exp_m1_r_addr[MAXC];
  bit hv_pat[MAXC];
  bit m_last_c = 1'b1;  // model of "last granted port", compute after reset

  // Observations used by the literal checks.
  int hd_last, cd_last, ca_last, ha_last, wen_cnt, cdone_cnt;
  int w1_n, m0w_n, m0r_n;
  logic [ADDR_RAM-1:0] w1_log[32], m0w_log[32], m0r_log[32];
  logic [N_BUF-1:0] m0w_en_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic sched_common(input int t, input bit is_c, input int end_c);
    if (is_c) exp_c_ack[t+1] = 1'b1; else exp_h_ack[t+1] = 1'b1;
    for (int c = t + 1; c < end_c; c++) exp_busy[c] = 1'b1;
    for (int c = t + 1; c < MAXC; c++) exp_mode[c] = is_c;
    if (is_c) exp_c_done[end_c] = 1'b1; else exp_h_done[end_c] = 1'b1;
    m_last_c = is_c;
  endtask

  task automatic sched_host_wr(input int t, input int bank, input int base, input int len);
    int acc = 0;
    int c = t + 2;
    if (len == 0) c = t + 2;
    else begin
      while (acc < len && c < MAXC) begin
        exp_h_ready[c] = 1'b1;
        if (hv_pat[c]) begin
          exp_m0_w_en[c]   = N_BUF'(1) << bank;
          exp_m0_w_addr[c] = ADDR_RAM'(base + acc);
          acc++;
        end
        c++;
      end
    end
    sched_common(t, 1'b0, c);
  endtask

  task automatic sched_host_rd(input int t, input int bank, input int base, input int len);
    for (int k = 0; k < len; k++) begin
      exp_m0_r_en[t+2+k]   = N_BUF'(1) << bank;
      exp_m0_r_addr[t+2+k] = ADDR_RAM'(base + k);
      exp_h_rvalid[t+3+k]  = 1'b1;
    end
    sched_common(t, 1'b0, (len == 0) ? t + 2 : t + 3 + len);
  endtask

  task automatic sched_comp(input int t, input int rb, input int wb, input int len);
    for (int k = 0; k < len; k++) begin
      exp_m1_r_en[t+2+k]          = 1'b1;
      exp_m1_r_addr[t+2+k]        = ADDR_RAM'(rb + k);
      exp_m1_w_en[t+2+PE_LAT+k]   = 1'b1;
      exp_m1_w_addr[t+2+PE_LAT+k] = ADDR_RAM'(wb + k);
    end
    sched_common(t, 1'b1, (len == 0) ? t + 2 : t + 2 + len + PE_LAT);
  endtask

  // A synchronous reset seen in cycle r wipes everything from r+1 on.
  task automatic sched_reset(input int r);
    for (int c = r + 1; c < MAXC; c++) begin
      exp_h_ack[c] = 0; exp_c_ack[c] = 0; exp_h_ready[c] = 0; exp_h_rvalid[c] = 0;
      exp_h_done[c] = 0; exp_c_done[c] = 0; exp_busy[c] = 0; exp_mode[c] = 0;
      exp_m1_w_en[c] = 0; exp_m1_r_en[c] = 0; exp_m0_w_en[c] = '0; exp_m0_r_en[c] = '0;
    end
    for (int c = r + 1; c < r + 4; c++) exp_zero[c] = 1'b1;
    m_last_c = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    h_valid = (cyc < MAXC) ? hv_pat[cyc] : 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_obs();
    hd_last = -1; cd_last = -1; ca_last = -1; ha_last = -1;
    wen_cnt = 0; cdone_cnt = 0; w1_n = 0; m0w_n = 0; m0r_n = 0; m0w_en_seen = '0;
  endtask

  // Per-cycle compare against the expectation table.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC) begin
        chk("h_ack",    32'(h_ack),    32'(exp_h_ack[cyc]));
        chk("c_ack",    32'(c_ack),    32'(exp_c_ack[cyc]));
        chk("h_ready",  32'(h_ready),  32'(exp_h_ready[cyc]));
        chk("h_rvalid", 32'(h_rvalid), 32'(exp_h_rvalid[cyc]));
        chk("h_done",   32'(h_done),   32'(exp_h_done[cyc]));
        chk("c_done",   32'(c_done),   32'(exp_c_done[cyc]));
        chk("busy",     32'(busy),     32'(exp_busy[cyc]));
        chk("mode",     32'(mode),     32'(exp_mode[cyc]));
        chk("m0_w_en",  32'(m0_w_en),  32'(exp_m0_w_en[cyc]));
        chk("m0_r_en",  32'(m0_r_en),  32'(exp_m0_r_en[cyc]));
        chk("m1_w_en",  32'(m1_w_en),  32'(exp_m1_w_en[cyc]));
        chk("m1_r_en",  32'(m1_r_en),  32'(exp_m1_r_en[cyc]));
        if (exp_m0_w_en[cyc] != '0) chk("m0_w_addr", 32'(m0_w_addr), 32'(exp_m0_w_addr[cyc]));
        if (exp_m0_r_en[cyc] != '0) chk("m0_r_addr", 32'(m0_r_addr), 32'(exp_m0_r_addr[cyc]));
        if (exp_m1_w_en[cyc]) chk("m1_w_addr", 32'(m1_w_addr), 32'(exp_m1_w_addr[cyc]));
        if (exp_m1_r_en[cyc]) chk("m1_r_addr", 32'(m1_r_addr), 32'(exp_m1_r_addr[cyc]));
        if (exp_zero[cyc]) begin
          chk("rst_addr", 32'({m0_w_addr, m0_r_addr, m1_w_addr}), 32'(0));
          chk("rst_m1_r_addr", 32'(m1_r_addr), 32'(0));
        end
      end
      if (h_done === 1'b1) hd_last = cyc;
      if (c_done === 1'b1) begin cd_last = cyc; cdone_cnt++; end
      if (c_ack === 1'b1) ca_last = cyc;
      if (h_ack === 1'b1) ha_last = cyc;
      if (m1_w_en === 1'b1) begin
        wen_cnt++;
        if (w1_n < 32) begin w1_log[w1_n] = m1_w_addr; w1_n++; end
      end
      if (m0_w_en !== '0 && m0w_n < 32) begin
        m0w_log[m0w_n] = m0_w_addr; m0w_n++; m0w_en_seen = m0_w_en;
      end
      if (m0_r_en !== '0 && m0r_n < 32) begin m0r_log[m0r_n] = m0_r_addr; m0r_n++; end
    end
  end

  initial begin
    int t, t2, t3;
    logic [ADDR_RAM-1:0] a;
    for (int c = 0; c < MAXC; c++) begin
      exp_h_ack[c] = 0; exp_c_ack[c] = 0; exp_h_ready[c] = 0; exp_h_rvalid[c] = 0;
      exp_h_done[c] = 0; exp_c_done[c] = 0; exp_busy[c] = 0; exp_mode[c] = 0;
      exp_m1_w_en[c] = 0; exp_m1_r_en[c] = 0; exp_zero[c] = 0; hv_pat[c] = 0;
      exp_m0_w_en[c] = '0; exp_m0_r_en[c] = '0;
      exp_m0_w_addr[c] = '0; exp_m0_r_addr[c] = '0;
      exp_m1_w_addr[c] = '0; exp_m1_r_addr[c] = '0;
    end
    for (int c = 1; c < 7; c++) exp_zero[c] = 1'b1;
    rst = 1'b1; h_req = 0; h_wr = 0; h_valid = 0; c_req = 0;
    h_bank = '0; h_base = '0; h_len = '0; c_rd_base = '0; c_wr_base = '0; c_len = '0;
    clear_obs();
    run_to(3);
    rst = 1'b0;
    run_to(8);

    // Host write, wrapping addresses, one stall on the second data cycle.
    t = cyc;
    hv_pat[t+2] = 1; hv_pat[t+4] = 1; hv_pat[t+5] = 1; hv_pat[t+6] = 1;
    sched_host_wr(t, 3, 1022, 4);
    clear_obs();
    h_req = 1; h_wr = 1; h_bank = 3; h_base = 1022; h_len = 4;
    tick(); tick();
    h_req = 0;
    run_to(t + 10);
    chk("hw_done_lat", 32'(hd_last - t), 32'd7);
    chk("hw_words", 32'(m0w_n), 32'd4);
    chk("hw_en", 32'(m0w_en_seen), 32'h08);
    a = m0w_log[0]; chk("hw_addr0", 32'(a), 32'd1022);
    a = m0w_log[1]; chk("hw_addr1", 32'(a), 32'd1023);
    a = m0w_log[2]; chk("hw_addr2", 32'(a), 32'd0);
    a = m0w_log[3]; chk("hw_addr3", 32'(a), 32'd1);

    // Host read bank 0, base 5, len 3.
    t = cyc;
    sched_host_rd(t, 0, 5, 3);
    clear_obs();
    h_req = 1; h_wr = 0; h_bank = 0; h_base = 5; h_len = 3;
    tick(); tick();
    h_req = 0;
    run_to(t + 9);
    chk("hr_done_lat", 32'(hd_last - t), 32'd6);
    chk("hr_words", 32'(m0r_n), 32'd3);
    a = m0r_log[2]; chk("hr_addr2", 32'(a), 32'd7);

    // Compute rd 0, wr 512, len 6.
    t = cyc;
    sched_comp(t, 0, 512, 6);
    clear_obs();
    c_req = 1; c_rd_base = 0; c_wr_base = 512; c_len = 6;
    tick(); tick();
    c_req = 0;
    run_to(t + 15);
    chk("cp_done_lat", 32'(cd_last - t), 32'd12);
    chk("cp_wb_count", 32'(wen_cnt), 32'd6);
    a = w1_log[0]; chk("cp_wb_addr0", 32'(a), 32'd512);
    a = w1_log[5]; chk("cp_wb_addr5", 32'(a), 32'd517);

    // Contention twice: host wins first, compute second, then lone host.
    t = cyc;
    if (!m_last_c) sched_comp(t, 200, 300, 3); else sched_host_rd(t, 2, 100, 2);
    clear_obs();
    h_req = 1; h_wr = 0; h_bank = 2; h_base = 100; h_len = 2;
    c_req = 1; c_rd_base = 200; c_wr_base = 300; c_len = 3;
    tick(); tick();
    h_req = 0;
    run_to(t + 5);
    t2 = cyc;
    if (m_last_c) sched_host_rd(t2, 1, 7, 1); else sched_comp(t2, 200, 300, 3);
    h_req = 1; h_bank = 1; h_base = 7; h_len = 1;
    tick(); tick();
    c_req = 0;
    run_to(t2 + 9);
    t3 = cyc;
    sched_host_rd(t3, 1, 7, 1);
    tick(); tick();
    h_req = 0;
    run_to(t3 + 7);
    chk("arb_c_ack", 32'(ca_last - t), 32'd6);
    chk("arb_h_ack", 32'(ha_last - t), 32'd15);

    // Zero-length compute burst.
    t = cyc;
    sched_comp(t, 0, 0, 0);
    clear_obs();
    c_req = 1; c_rd_base = 9; c_wr_base = 9; c_len = 0;
    tick(); tick();
    c_req = 0;
    run_to(t + 5);
    chk("z_done_lat", 32'(cd_last - t), 32'd2);
    chk("z_ack_lat", 32'(ca_last - t), 32'd1);

    // Reset on the 5th read of a 16-word compute burst.
    t = cyc;
    sched_comp(t, 40, 60, 16);
    clear_obs();
    c_req = 1; c_rd_base = 40; c_wr_base = 60; c_len = 16;
    tick(); tick();
    c_req = 0;
    run_to(t + 6);
    sched_reset(t + 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_to(t + 45);
    chk("rst_wb_count", 32'(wen_cnt), 32'd1);
    chk("rst_no_done", 32'(cdone_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
